// File: rtl/lc3_mem_arbiter.sv
// LC3 unified-memory arbiter.
// The fetch stage and the MemAccess stage share one single-ported memory.
// This block serialises their requests and drives the memory request/ack
// handshake. It returns results with one-cycle completion pulses.
// A data-streak limit keeps fetch from starving.
// A wait watchdog bounds how long a stalled memory can hold the core.
//
// state  | meaning
// -------+-----------------------------------------------------------
// IDLE   | no transaction; arbitrate and issue on a sampled request
// BUSY_I | fetch read outstanding; waiting for mem_ack or timeout
// BUSY_D | data read/write outstanding; waiting for mem_ack or timeout
// DONE   | completion pulse cycle; requests ignored (no double issue)

module lc3_mem_arbiter #(
  parameter int MAX_DATA_STREAK = 4,
  parameter int TIMEOUT         = 64
) (
  input  logic        clk,
  input  logic        reset,
  // fetch port
  input  logic        instrmem_rd,
  input  logic [15:0] pc,
  output logic [15:0] Instr_dout,
  output logic        complete_instr,
  // data port
  input  logic        Data_req,
  input  logic        Data_rd,
  input  logic [15:0] Data_addr,
  input  logic [15:0] Data_din,
  output logic [15:0] Data_dout,
  output logic        complete_data,
  // memory side
  output logic        mem_req,
  output logic        mem_we,
  output logic [15:0] mem_addr,
  output logic [15:0] mem_wdata,
  input  logic [15:0] mem_rdata,
  input  logic        mem_ack,
  // status
  output logic        busy,
  output logic        err_timeout
);

  localparam int STREAK_W = (MAX_DATA_STREAK < 1) ? 1 : $clog2(MAX_DATA_STREAK + 1);
  localparam int WAIT_W   = (TIMEOUT < 2) ? 1 : $clog2(TIMEOUT);

  localparam logic [STREAK_W-1:0] STREAK_MAX = STREAK_W'(MAX_DATA_STREAK);
  localparam logic [STREAK_W-1:0] STREAK_ONE = STREAK_W'(1);
  // The counter starts at 0 in the first busy cycle, so TIMEOUT-1 marks the last one.
  localparam logic [WAIT_W-1:0]   WAIT_LAST  = WAIT_W'(TIMEOUT - 1);
  localparam logic [WAIT_W-1:0]   WAIT_ONE   = WAIT_W'(1);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    BUSY_I = 2'd1,
    BUSY_D = 2'd2,
    DONE   = 2'd3
  } state_t;

  state_t              state_q;
  logic [STREAK_W-1:0] streak_q;
  logic [STREAK_W-1:0] streak_d;
  logic [WAIT_W-1:0]   wait_q;

  logic        mem_req_q;
  logic        mem_we_q;
  logic [15:0] mem_addr_q;
  logic [15:0] mem_wdata_q;
  logic [15:0] instr_dout_q;
  logic [15:0] data_dout_q;
  logic        complete_instr_q;
  logic        complete_data_q;
  logic        err_timeout_q;

  logic grant_data;
  logic grant_instr;
  logic timeout_hit;

  // Arbitration: data normally wins a tie, until it has won MAX_DATA_STREAK
  // times in a row over a waiting fetch.
  always_comb begin
    grant_data  = Data_req && (!instrmem_rd || (streak_q < STREAK_MAX));
    grant_instr = instrmem_rd && !grant_data;
    streak_d    = streak_q;
    if (grant_data) begin
      if (instrmem_rd) begin
        streak_d = (streak_q == STREAK_MAX) ? streak_q : streak_q + STREAK_ONE;
      end else begin
        streak_d = '0;
      end
    end else if (grant_instr) begin
      streak_d = '0;
    end
  end

  assign timeout_hit = (wait_q == WAIT_LAST);

  // Transaction FSM with all outputs registered.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q          <= IDLE;
      streak_q         <= '0;
      wait_q           <= '0;
      mem_req_q        <= 1'b0;
      mem_we_q         <= 1'b0;
      mem_addr_q       <= 16'h0000;
      mem_wdata_q      <= 16'h0000;
      instr_dout_q     <= 16'h0000;
      data_dout_q      <= 16'h0000;
      complete_instr_q <= 1'b0;
      complete_data_q  <= 1'b0;
      err_timeout_q    <= 1'b0;
    end else begin
      complete_instr_q <= 1'b0;
      complete_data_q  <= 1'b0;
      case (state_q)
        IDLE: begin
          wait_q   <= '0;
          streak_q <= streak_d;
          if (grant_data) begin
            state_q     <= BUSY_D;
            mem_req_q   <= 1'b1;
            mem_we_q    <= ~Data_rd;
            mem_addr_q  <= Data_addr;
            mem_wdata_q <= Data_din;
          end else if (grant_instr) begin
            state_q     <= BUSY_I;
            mem_req_q   <= 1'b1;
            mem_we_q    <= 1'b0;
            mem_addr_q  <= pc;
            mem_wdata_q <= 16'h0000;
          end
        end

        BUSY_I, BUSY_D: begin
          // An ack on the final waiting cycle still counts as a normal completion.
          if (mem_ack) begin
            mem_req_q <= 1'b0;
            state_q   <= DONE;
            if (state_q == BUSY_I) begin
              instr_dout_q     <= mem_rdata;
              complete_instr_q <= 1'b1;
            end else begin
              if (!mem_we_q) begin
                data_dout_q <= mem_rdata;
              end
              complete_data_q <= 1'b1;
            end
          end else if (timeout_hit) begin
            mem_req_q     <= 1'b0;
            err_timeout_q <= 1'b1;
            state_q       <= DONE;
            if (state_q == BUSY_I) begin
              instr_dout_q     <= 16'h0000;
              complete_instr_q <= 1'b1;
            end else begin
              data_dout_q     <= 16'h0000;
              complete_data_q <= 1'b1;
            end
          end else begin
            wait_q <= wait_q + WAIT_ONE;
          end
        end

        DONE: begin
          state_q <= IDLE;
        end

        default: begin
          state_q <= IDLE;
        end
      endcase
    end
  end

  assign mem_req        = mem_req_q;
  assign mem_we         = mem_we_q;
  assign mem_addr       = mem_addr_q;
  assign mem_wdata      = mem_wdata_q;
  assign Instr_dout     = instr_dout_q;
  assign Data_dout      = data_dout_q;
  assign complete_instr = complete_instr_q;
  assign complete_data  = complete_data_q;
  assign err_timeout    = err_timeout_q;
  assign busy           = (state_q == BUSY_I) || (state_q == BUSY_D);

endmodule

// File: tb/tb_lc3_mem_arbiter.sv
// Directed bench for lc3_mem_arbiter.
// Inputs are driven and outputs are sampled 1 ns after each rising edge.

module tb_lc3_mem_arbiter;

  logic        clk = 1'b0;
  logic        reset;
  logic        instrmem_rd;
  logic [15:0] pc;
  logic [15:0] Instr_dout;
  logic        complete_instr;
  logic        Data_req;
  logic        Data_rd;
  logic [15:0] Data_addr;
  logic [15:0] Data_din;
  logic [15:0] Data_dout;
  logic        complete_data;
  logic        mem_req;
  logic        mem_we;
  logic [15:0] mem_addr;
  logic [15:0] mem_wdata;
  logic [15:0] mem_rdata;
  logic        mem_ack;
  logic        busy;
  logic        err_timeout;

  int tests_run    = 0;
  int tests_failed = 0;

  lc3_mem_arbiter #(.MAX_DATA_STREAK(4), .TIMEOUT(64)) dut (
    .clk            (clk),
    .reset          (reset),
    .instrmem_rd    (instrmem_rd),
    .pc             (pc),
    .Instr_dout     (Instr_dout),
    .complete_instr (complete_instr),
    .Data_req       (Data_req),
    .Data_rd        (Data_rd),
    .Data_addr      (Data_addr),
    .Data_din       (Data_din),
    .Data_dout      (Data_dout),
    .complete_data  (complete_data),
    .mem_req        (mem_req),
    .mem_we         (mem_we),
    .mem_addr       (mem_addr),
    .mem_wdata      (mem_wdata),
    .mem_rdata      (mem_rdata),
    .mem_ack        (mem_ack),
    .busy           (busy),
    .err_timeout    (err_timeout)
  );

  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests_run++;
    assert (obs === exp) else begin
      tests_failed++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int  cnt;
    bit  exp_d;
    bit  exp_order [6];

    reset       = 1'b1;
    instrmem_rd = 1'b0;
    pc          = 16'h0000;
    Data_req    = 1'b0;
    Data_rd     = 1'b0;
    Data_addr   = 16'h0000;
    Data_din    = 16'h0000;
    mem_rdata   = 16'h0000;
    mem_ack     = 1'b0;
    step();
    step();

    // Reset state
    chk("rst_mem_req", mem_req, 0);
    chk("rst_mem_we", mem_we, 0);
    chk("rst_mem_addr", mem_addr, 16'h0000);
    chk("rst_mem_wdata", mem_wdata, 16'h0000);
    chk("rst_instr_dout", Instr_dout, 16'h0000);
    chk("rst_data_dout", Data_dout, 16'h0000);
    chk("rst_complete_i", complete_instr, 0);
    chk("rst_complete_d", complete_data, 0);
    chk("rst_busy", busy, 0);
    chk("rst_err", err_timeout, 0);
    reset = 1'b0;
    step();

    // Test 1: fetch only, zero-wait memory
    instrmem_rd = 1'b1;
    pc          = 16'h3000;
    step();
    chk("t1_mem_req", mem_req, 1);
    chk("t1_mem_addr", mem_addr, 16'h3000);
    chk("t1_mem_we", mem_we, 0);
    chk("t1_busy", busy, 1);
    chk("t1_no_early_complete", complete_instr, 0);
    mem_ack   = 1'b1;
    mem_rdata = 16'h1234;
    step();
    mem_ack     = 1'b0;
    instrmem_rd = 1'b0;
    chk("t1_complete_i", complete_instr, 1);
    chk("t1_complete_d", complete_data, 0);
    chk("t1_instr_dout", Instr_dout, 16'h1234);
    chk("t1_mem_req_drop", mem_req, 0);
    chk("t1_busy_done", busy, 0);
    step();
    chk("t1_pulse_end", complete_instr, 0);
    chk("t1_dout_held", Instr_dout, 16'h1234);

    // Data read so the following write has a non-zero Data_dout to preserve
    Data_req  = 1'b1;
    Data_rd   = 1'b1;
    Data_addr = 16'h4001;
    mem_ack   = 1'b1;
    mem_rdata = 16'hA5A5;
    step();
    chk("rd_mem_req", mem_req, 1);
    chk("rd_mem_we", mem_we, 0);
    step();
    Data_req = 1'b0;
    mem_ack  = 1'b0;
    chk("rd_complete_d", complete_data, 1);
    chk("rd_data_dout", Data_dout, 16'hA5A5);
    step();

    // Test 2: data write, memory acks after 3 wait cycles
    Data_req  = 1'b1;
    Data_rd   = 1'b0;
    Data_addr = 16'h4000;
    Data_din  = 16'hBEEF;
    mem_rdata = 16'h5555;
    step();
    for (int i = 0; i < 4; i++) begin
      chk("t2_mem_req", mem_req, 1);
      chk("t2_mem_we", mem_we, 1);
      chk("t2_mem_wdata", mem_wdata, 16'hBEEF);
      chk("t2_mem_addr", mem_addr, 16'h4000);
      chk("t2_no_complete", complete_data, 0);
      if (i == 3) mem_ack = 1'b1;
      step();
    end
    mem_ack  = 1'b0;
    Data_req = 1'b0;
    chk("t2_complete_d", complete_data, 1);
    chk("t2_dout_unchanged", Data_dout, 16'hA5A5);
    chk("t2_mem_req_drop", mem_req, 0);
    step();
    chk("t2_pulse_end", complete_data, 0);

    // Test 3: both requests held, ack always high, expect D,D,D,D,I,D
    exp_order   = '{1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 1'b1};
    instrmem_rd = 1'b1;
    pc          = 16'h3100;
    Data_req    = 1'b1;
    Data_rd     = 1'b1;
    Data_addr   = 16'h4100;
    mem_ack     = 1'b1;
    mem_rdata   = 16'h7777;
    for (int g = 0; g < 6; g++) begin
      exp_d = exp_order[g];
      step();
      chk("t3_grant_addr", mem_addr, exp_d ? 16'h4100 : 16'h3100);
      chk("t3_busy", busy, 1);
      step();
      chk("t3_complete_d", complete_data, exp_d);
      chk("t3_complete_i", complete_instr, !exp_d);
      step();
      chk("t3_idle_no_pulse", {complete_instr, complete_data}, 2'b00);
    end
    instrmem_rd = 1'b0;
    Data_req    = 1'b0;
    mem_ack     = 1'b0;
    chk("t3_instr_dout", Instr_dout, 16'h7777);
    step();

    // Test 4: data read with no ack, timeout after 64 busy cycles
    Data_req  = 1'b1;
    Data_rd   = 1'b1;
    Data_addr = 16'h5000;
    step();
    chk("t4_mem_addr", mem_addr, 16'h5000);
    cnt = 0;
    while (mem_req && cnt < 100) begin
      cnt++;
      if (cnt == 32) chk("t4_err_mid", err_timeout, 0);
      step();
    end
    chk("t4_busy_cycles", cnt, 64);
    chk("t4_complete_d", complete_data, 1);
    chk("t4_data_dout_zero", Data_dout, 16'h0000);
    chk("t4_err_set", err_timeout, 1);
    Data_req = 1'b0;
    step();
    chk("t4_err_sticky", err_timeout, 1);
    chk("t4_pulse_end", complete_data, 0);
    step();

    // Test 5: reset for one cycle during BUSY_I
    instrmem_rd = 1'b1;
    pc          = 16'h3200;
    step();
    chk("t5_busy_before", busy, 1);
    reset = 1'b1;
    step();
    reset       = 1'b0;
    instrmem_rd = 1'b0;
    chk("t5_idle", busy, 0);
    chk("t5_mem_req", mem_req, 0);
    chk("t5_no_complete", complete_instr, 0);
    chk("t5_err_clear", err_timeout, 0);
    step();
    chk("t5_no_late_complete", complete_instr, 0);
    chk("t5_still_idle", busy, 0);

    // Test 6: fetch held high with ack always high; one transaction per 3 cycles
    instrmem_rd = 1'b1;
    pc          = 16'h3300;
    mem_ack     = 1'b1;
    mem_rdata   = 16'hABCD;
    for (int k = 1; k <= 12; k++) begin
      step();
      chk("t6_mem_req", mem_req, (k % 3) == 1);
      chk("t6_complete_i", complete_instr, (k % 3) == 2);
      if ((k % 3) == 2) chk("t6_instr_dout", Instr_dout, 16'hABCD);
    end
    instrmem_rd = 1'b0;
    mem_ack     = 1'b0;
    step();
    step();
    chk("t6_final_idle", busy, 0);

    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
